fwd_ctrl: RTL and testbench
===========================

Name: fwd_ctrl

Overview:
- Pipeline forwarding and hazard controller for the 5-stage core.
- Tracks in-flight destination registers across the EX, MEM and WB stages.
- Generates the registered 2-bit operand-select codes consumed by the EX-stage 3-input operand muxes (00 regfile, 01 MEM-stage result, 10 WB-stage result, 11 never driven), plus a load-use stall request for IF/ID.

Parameters:
- REG_ADDR_W, 5, register index width.
- NUM_REGS, 32, architectural register count; index 0 is hardwired zero.

Ports:
- clk_i  input  1  core clock, rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- id_valid_i  input  1  ID holds a real instruction.
- id_rs1_i  input  REG_ADDR_W  ID source 1 index.
- id_rs2_i  input  REG_ADDR_W  ID source 2 index.
- id_rs1_ren_i  input  1  instruction reads rs1.
- id_rs2_ren_i  input  1  instruction reads rs2.
- id_rd_i  input  REG_ADDR_W  ID destination index.
- id_we_i  input  1  instruction writes rd.
- id_is_load_i  input  1  instruction is a load.
- flush_i  input  1  squash the ID instruction (taken branch/jump resolved in EX).
- stall_o  output  1  load-use stall: hold PC and IF/ID.
- fwd_a_sel_o  output  2  EX operand A select.
- fwd_b_sel_o  output  2  EX operand B select.

Behaviour:
- Clock and reset: one clock, clk_i; reset is asynchronous and active-low on rst_ni.
- Internal stage records:
  - EX record: valid, rd, we, is_load.
  - MEM record: valid, rd, we, is_load.
  - WB record: valid, rd, we.
- Reset: all records invalid with we=0; fwd_a_sel_o and fwd_b_sel_o = 2'b00; stall_o = 0.
  - Reset asserted mid-operation clears everything immediately; the first edge after release sees an empty pipe.
- Effective ID write-enable: a record counts as writing only if we=1, valid=1 and rd!=0.
- stall_o (combinational):
  - Asserted when id_valid_i=1, flush_i=0, the EX record is a valid writing load, and rd matches (id_rs1_i with id_rs1_ren_i) or (id_rs2_i with id_rs2_ren_i).
  - A source index of 0 never stalls.
- Every rising edge:
  - WB <= MEM; MEM <= EX.
  - EX <= ID fields, or a bubble (valid=0, we=0) if stall_o, flush_i or !id_valid_i.
- Select computation for operand A (operand B identical using rs2/ren2), registered on the same edge, so the sels are valid during the EX cycle of the entering instruction:
  - 01 if ren=1, rs!=0, the current EX record writes rs and is not a load.
  - else 10 if ren=1, rs!=0 and the current MEM record writes rs.
  - else 00.
  - When EX receives a bubble, both sels register 00.
- Priority: the newest producer wins (MEM-stage result over WB-stage result) when both match.
- After a load-use stall, the load sits in MEM and the consumer enters EX with sel 10. Exactly one stall cycle per load-use hazard.
- flush_i and stall condition together: flush wins; stall_o=0 and EX receives a bubble.
- The regfile is write-first, so producers already retiring from WB need no forwarding here.
- Latency: sels change one clock after the ID inputs; stall_o has zero latency.

Optional Feature:
- Macro: FWD_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt_o, 32-bit.
  - Reset to 0; increments on each edge where stall_o=1.
  - Wraps from 0xFFFFFFFF to 0 without saturation.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Back-to-back RAW: add x5 in ID, then next cycle sub reads x5 as rs1 -> fwd_a_sel_o=01 during sub's EX; stall_o=0 throughout.
- Distance-2 RAW: add x6; nop; or reads x6 as rs2 -> fwd_b_sel_o=10, fwd_a_sel_o=00.
- Double producer: add x5; addi x5; and reads x5 on both operands -> both sels=01 (newest wins). Separately, any producer writing x0 with a consumer reading x0 -> sels 00.
- Load-use: lw x7; add x8,x1,x7 -> stall_o=1 for exactly one cycle; the EX bubble shows sels 00; then add in EX with fwd_b_sel_o=10. With FWD_STALL_CNT_EN, stall_cnt_o=1.
- Flush during hazard: lw x7; consumer of x7 in ID with flush_i=1 -> stall_o=0; next EX is a bubble with sels 00.
- Reset mid-stream: rst_ni low while sels=01 -> sels 00 and stall 0 immediately (asynchronously); after release, a consumer of the pre-reset rd gets sel 00.

Source files
------------

// File: rtl/fwd_ctrl_if.sv
// Forwarding-controller bus: ID-stage instruction fields in, stall request and
// EX operand-select codes out. The master drives the ID fields, the slave
// (fwd_ctrl) returns stall_o, the select codes and a debug view of the stage
// records.
// Optional feature macro: FWD_STALL_CNT_EN adds the 32-bit stall_cnt_o output.
//
// ID fields are sampled on every rising clk edge. There is no valid/ready
// handshake: id_valid_i qualifies the fields, stall_o (combinational) tells the
// front end to hold PC and IF/ID, and flush_i squashes the ID instruction.
interface fwd_ctrl_if #(
  parameter int REG_ADDR_W = 5
);
  logic                    id_valid_i;
  logic [REG_ADDR_W-1:0]   id_rs1_i;
  logic [REG_ADDR_W-1:0]   id_rs2_i;
  logic                    id_rs1_ren_i;
  logic                    id_rs2_ren_i;
  logic [REG_ADDR_W-1:0]   id_rd_i;
  logic                    id_we_i;
  logic                    id_is_load_i;
  logic                    flush_i;
  logic                    stall_o;
  logic [1:0]              fwd_a_sel_o;
  logic [1:0]              fwd_b_sel_o;
  // {EX record, MEM record, WB record}; EX/MEM are {valid, we, is_load, rd},
  // WB is {valid, we, rd}.
  logic [3*REG_ADDR_W+7:0] dbg_rec_o;
`ifdef FWD_STALL_CNT_EN
  logic [31:0]             stall_cnt_o;
`endif

  modport master (
    output id_valid_i, id_rs1_i, id_rs2_i, id_rs1_ren_i, id_rs2_ren_i,
           id_rd_i, id_we_i, id_is_load_i, flush_i,
    input  stall_o, fwd_a_sel_o, fwd_b_sel_o, dbg_rec_o
`ifdef FWD_STALL_CNT_EN
    , input stall_cnt_o
`endif
  );

  modport slave (
    input  id_valid_i, id_rs1_i, id_rs2_i, id_rs1_ren_i, id_rs2_ren_i,
           id_rd_i, id_we_i, id_is_load_i, flush_i,
    output stall_o, fwd_a_sel_o, fwd_b_sel_o, dbg_rec_o
`ifdef FWD_STALL_CNT_EN
    , output stall_cnt_o
`endif
  );
endinterface

// File: rtl/fwd_ctrl.sv
// Forwarding and load-use hazard controller for the 5-stage core.
// Tracks destination registers in EX, MEM and WB and registers the 2-bit
// EX operand-select codes (00 regfile, 01 MEM result, 10 WB result) on the
// edge where the ID instruction enters EX. A load in EX whose rd is read by
// the ID instruction raises stall_o for one cycle and inserts an EX bubble.
// Optional feature macro: FWD_STALL_CNT_EN (free-running 32-bit stall counter).
module fwd_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_REGS   = 32
) (
  input logic       clk_i,
  input logic       rst_ni,
  fwd_ctrl_if.slave bus
);

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic                  is_load;
    logic [REG_ADDR_W-1:0] rd;
  } rec_t;

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic [REG_ADDR_W-1:0] rd;
  } wb_rec_t;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  rec_t    ex_q, mem_q;
  wb_rec_t wb_q;
  logic [1:0] sel_a_q, sel_b_q;
  logic [1:0] sel_a_nxt, sel_b_nxt;
  logic       ex_wr, mem_wr;
  logic       stall;
  logic       bubble;

  // Index 0 is hardwired zero; indices past NUM_REGS do not exist.
  function automatic logic real_reg(input logic [REG_ADDR_W-1:0] r);
    return (r != '0) && (int'(r) < NUM_REGS);
  endfunction

  // A source operand matches a producer only if it is actually read.
  function automatic logic src_hit(input logic                  ren,
                                   input logic [REG_ADDR_W-1:0] rs,
                                   input logic                  prod_wr,
                                   input logic [REG_ADDR_W-1:0] prod_rd);
    return ren && real_reg(rs) && prod_wr && (rs == prod_rd);
  endfunction

  assign ex_wr  = ex_q.valid && ex_q.we && real_reg(ex_q.rd);
  assign mem_wr = mem_q.valid && mem_q.we && real_reg(mem_q.rd);

  // Load-use: the load result does not exist until MEM completes; flush wins.
  assign stall = bus.id_valid_i && !bus.flush_i && ex_wr && ex_q.is_load &&
                 (src_hit(bus.id_rs1_ren_i, bus.id_rs1_i, ex_wr, ex_q.rd) ||
                  src_hit(bus.id_rs2_ren_i, bus.id_rs2_i, ex_wr, ex_q.rd));

  assign bubble = stall || bus.flush_i || !bus.id_valid_i;

  // Next select codes: the current EX producer moves to MEM on this edge and is
  // newest, so it beats the current MEM producer (which moves to WB).
  always_comb begin
    sel_a_nxt = SEL_RF;
    sel_b_nxt = SEL_RF;
    if (!bubble) begin
      if (src_hit(bus.id_rs1_ren_i, bus.id_rs1_i, ex_wr && !ex_q.is_load, ex_q.rd))
        sel_a_nxt = SEL_MEM;
      else if (src_hit(bus.id_rs1_ren_i, bus.id_rs1_i, mem_wr, mem_q.rd))
        sel_a_nxt = SEL_WB;
      if (src_hit(bus.id_rs2_ren_i, bus.id_rs2_i, ex_wr && !ex_q.is_load, ex_q.rd))
        sel_b_nxt = SEL_MEM;
      else if (src_hit(bus.id_rs2_ren_i, bus.id_rs2_i, mem_wr, mem_q.rd))
        sel_b_nxt = SEL_WB;
    end
  end

  // Advance the stage records and register the select codes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      sel_a_q <= SEL_RF;
      sel_b_q <= SEL_RF;
    end else begin
      wb_q.valid <= mem_q.valid;
      wb_q.we    <= mem_q.we;
      wb_q.rd    <= mem_q.rd;
      mem_q      <= ex_q;
      if (bubble) begin
        ex_q <= '0;
      end else begin
        ex_q.valid   <= 1'b1;
        ex_q.we      <= bus.id_we_i;
        ex_q.is_load <= bus.id_is_load_i;
        ex_q.rd      <= bus.id_rd_i;
      end
      sel_a_q <= sel_a_nxt;
      sel_b_q <= sel_b_nxt;
    end
  end

`ifdef FWD_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Count stall cycles; wraps naturally at 2^32.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    stall_cnt_q <= '0;
    else if (stall) stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign bus.stall_cnt_o = stall_cnt_q;
`endif

  assign bus.stall_o     = stall;
  assign bus.fwd_a_sel_o = sel_a_q;
  assign bus.fwd_b_sel_o = sel_b_q;
  assign bus.dbg_rec_o   = {ex_q, mem_q, wb_q};

endmodule

// File: tb/tb_fwd_ctrl.sv
// Directed bench for fwd_ctrl: each step drives one ID instruction, checks the
// combinational stall_o, queues the select codes expected one edge later and
// compares them after that edge.
module tb_fwd_ctrl;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  logic [3:0] exp_q[$];

  fwd_ctrl_if #(.REG_ADDR_W(5)) bus();

  fwd_ctrl #(.REG_ADDR_W(5), .NUM_REGS(32)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input logic v, input logic [4:0] rs1, input logic r1,
                       input logic [4:0] rs2, input logic r2, input logic [4:0] rd,
                       input logic we, input logic ld, input logic fl);
    bus.id_valid_i   = v;
    bus.id_rs1_i     = rs1;
    bus.id_rs1_ren_i = r1;
    bus.id_rs2_i     = rs2;
    bus.id_rs2_ren_i = r2;
    bus.id_rd_i      = rd;
    bus.id_we_i      = we;
    bus.id_is_load_i = ld;
    bus.flush_i      = fl;
  endtask

  // One ID cycle: check stall now, check select codes after the next edge.
  task automatic step(input string tag, input logic v, input logic [4:0] rs1,
                      input logic r1, input logic [4:0] rs2, input logic r2,
                      input logic [4:0] rd, input logic we, input logic ld,
                      input logic fl, input logic exp_stall,
                      input logic [1:0] ea, input logic [1:0] eb);
    logic [3:0] e;
    @(negedge clk);
    drive(v, rs1, r1, rs2, r2, rd, we, ld, fl);
    #1;
    chk({tag, "_stall"}, 32'(bus.stall_o), 32'(exp_stall));
    exp_q.push_back({ea, eb});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, "_sel_a"}, 32'(bus.fwd_a_sel_o), 32'(e[3:2]));
    chk({tag, "_sel_b"}, 32'(bus.fwd_b_sel_o), 32'(e[1:0]));
  endtask

  task automatic nop(input string tag);
    step(tag, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel_a", 32'(bus.fwd_a_sel_o), 32'd0);
    chk("rst_sel_b", 32'(bus.fwd_b_sel_o), 32'd0);
    chk("rst_stall", 32'(bus.stall_o), 32'd0);
`ifdef FWD_STALL_CNT_EN
    chk("rst_cnt", bus.stall_cnt_o, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back RAW: add x5; sub x9,x5,x3
    step("b2b_add", 1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 0, 2'b00, 2'b00);
    step("b2b_sub", 1, 5'd5, 1, 5'd3, 1, 5'd9, 1, 0, 0, 0, 2'b01, 2'b00);
    nop("b2b_n0"); nop("b2b_n1");

    // Distance-2 RAW: add x6; nop; or x10,x4,x6
    step("d2_add", 1, 5'd1, 1, 5'd2, 1, 5'd6, 1, 0, 0, 0, 2'b00, 2'b00);
    nop("d2_gap");
    step("d2_or", 1, 5'd4, 1, 5'd6, 1, 5'd10, 1, 0, 0, 0, 2'b00, 2'b10);
    nop("d2_n0"); nop("d2_n1");

    // Double producer: add x5; addi x5,x5; and x11,x5,x5 -> newest wins
    step("dp_add", 1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 0, 2'b00, 2'b00);
    step("dp_addi", 1, 5'd5, 1, 5'd0, 0, 5'd5, 1, 0, 0, 0, 2'b01, 2'b00);
    step("dp_and", 1, 5'd5, 1, 5'd5, 1, 5'd11, 1, 0, 0, 0, 2'b01, 2'b01);
    nop("dp_n0"); nop("dp_n1");

    // Producer writes x0; consumer reads x0 on both operands
    step("x0_prod", 1, 5'd1, 1, 5'd2, 1, 5'd0, 1, 0, 0, 0, 2'b00, 2'b00);
    step("x0_cons", 1, 5'd0, 1, 5'd0, 1, 5'd12, 1, 0, 0, 0, 2'b00, 2'b00);
    nop("x0_n0"); nop("x0_n1");

    // Load-use: lw x7; add x8,x1,x7 -> one stall, bubble, then WB select
    step("lu_lw", 1, 5'd1, 1, 5'd0, 0, 5'd7, 1, 1, 0, 0, 2'b00, 2'b00);
    step("lu_stall", 1, 5'd1, 1, 5'd7, 1, 5'd8, 1, 0, 0, 1, 2'b00, 2'b00);
    step("lu_add", 1, 5'd1, 1, 5'd7, 1, 5'd8, 1, 0, 0, 0, 2'b00, 2'b10);
`ifdef FWD_STALL_CNT_EN
    chk("lu_cnt", bus.stall_cnt_o, 32'd1);
`endif
    nop("lu_n0"); nop("lu_n1");

    // Flush during hazard: flush wins, bubble enters EX
    step("fl_lw", 1, 5'd1, 1, 5'd0, 0, 5'd7, 1, 1, 0, 0, 2'b00, 2'b00);
    step("fl_flush", 1, 5'd3, 1, 5'd7, 1, 5'd13, 1, 0, 1, 0, 2'b00, 2'b00);
    step("fl_next", 1, 5'd3, 1, 5'd7, 1, 5'd13, 1, 0, 0, 0, 2'b00, 2'b10);
    nop("fl_n0"); nop("fl_n1");

    // Reset mid-stream: sels at 01 and a pending load-use stall
    step("rs_add", 1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 0, 2'b00, 2'b00);
    step("rs_lw", 1, 5'd5, 1, 5'd0, 0, 5'd7, 1, 1, 0, 0, 2'b01, 2'b00);
    @(negedge clk);
    drive(1, 5'd7, 1, 5'd0, 0, 5'd14, 1, 0, 0);
    #1;
    chk("rs_pre_stall", 32'(bus.stall_o), 32'd1);
    chk("rs_pre_sel_a", 32'(bus.fwd_a_sel_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rs_async_stall", 32'(bus.stall_o), 32'd0);
    chk("rs_async_sel_a", 32'(bus.fwd_a_sel_o), 32'd0);
    chk("rs_async_sel_b", 32'(bus.fwd_b_sel_o), 32'd0);
`ifdef FWD_STALL_CNT_EN
    chk("rs_async_cnt", bus.stall_cnt_o, 32'd0);
`endif
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step("rs_after", 1, 5'd5, 1, 5'd7, 1, 5'd15, 1, 0, 0, 0, 2'b00, 2'b00);
    nop("rs_n0");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
